// File: rtl/life_pkg.sv
// Shared definitions for the 8x8 Game-of-Life sequencer.
//   life_state_t : sequencer FSM states
//   GRID_W       : number of cells (8x8, cell (r,c) at bit r*8+c)
//   halt_cond()  : true when a candidate generation is a still life or empty
package life_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} life_state_t;

    localparam int GRID_W = 64;

    function automatic logic halt_cond(input logic [GRID_W-1:0] cur,
                                       input logic [GRID_W-1:0] nxt);
        return (nxt == cur) || (nxt == '0);
    endfunction

endpackage

// File: rtl/rate_tick.sv
// Programmable rate divider. Produces one tick every (limit+1) enabled clocks.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the divider and latch a new limit
//   enable     : count this cycle
//   limit      : terminal count, sampled only while clear is high
//   tick       : combinational, high in the enabled cycle where the count hits the limit
module rate_tick #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] limit,
    output logic             tick
);

    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] limit_reg;

    assign tick = enable && (count_reg == limit_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            limit_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
            limit_reg <= limit;
        end else if (enable) begin
            if (tick) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/life_seq_ctrl.sv
// Sequencer for the 8x8 Game-of-Life engine. Holds the generation register,
// which feeds an external combinational next-generation block, and commits
// that block's result on step, or at a programmable rate while running.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   seed, load  : load pattern (load pulse wins over every other command)
//   run         : level, free-run while high
//   step, pause : single-cycle command pulses
//   halt_en     : stop automatically on still life or extinction
//   speed_div   : commit every speed_div+1 clocks, sampled when RUN is entered
//   next_grid   : next generation computed from grid
//   grid        : current generation
//   gen_count   : saturating count of commits since last load
//   busy, stable, extinct, halted : status
module life_seq_ctrl
    import life_pkg::*;
#(
    parameter int DIV_W = 24,
    parameter int GEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] seed,
    input  logic              load,
    input  logic              run,
    input  logic              step,
    input  logic              pause,
    input  logic              halt_en,
    input  logic [DIV_W-1:0]  speed_div,
    input  logic [GRID_W-1:0] next_grid,
    output logic [GRID_W-1:0] grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy,
    output logic              stable,
    output logic              extinct,
    output logic              halted
);

    life_state_t       state_reg, state_next;
    logic [GRID_W-1:0] grid_reg;
    logic [GEN_W-1:0]  gen_count_reg;
    logic              stable_reg;
    logic              extinct_reg;

    logic commit;
    logic div_clear;
    logic div_enable;
    logic div_tick;
    logic stop_now;

    rate_tick #(.DIV_W(DIV_W)) u_rate_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (div_clear),
        .enable (div_enable),
        .limit  (speed_div),
        .tick   (div_tick)
    );

    assign stop_now = halt_en && halt_cond(grid_reg, next_grid);

    // Next state and commit strobe. load is checked first so it overrides
    // every state, HALT included; pause outranks run.
    always_comb begin
        state_next = state_reg;
        commit     = 1'b0;
        div_clear  = 1'b0;
        div_enable = 1'b0;
        if (load) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (pause) begin
                        state_next = IDLE;
                    end else if (run) begin
                        state_next = RUN;
                        div_clear  = 1'b1;
                    end else if (step) begin
                        state_next = STEP;
                    end
                end
                STEP: begin
                    commit     = 1'b1;
                    state_next = stop_now ? HALT : IDLE;
                end
                RUN: begin
                    // Leaving RUN never commits; the partial divider count is dropped
                    // because the next entry clears it anyway.
                    if (pause || !run) begin
                        state_next = IDLE;
                    end else begin
                        div_enable = 1'b1;
                        if (div_tick) begin
                            commit = 1'b1;
                            if (stop_now) begin
                                state_next = HALT;
                            end
                        end
                    end
                end
                HALT: state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            grid_reg      <= '0;
            gen_count_reg <= '0;
            stable_reg    <= 1'b0;
            extinct_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (load) begin
                grid_reg      <= seed;
                gen_count_reg <= '0;
                stable_reg    <= 1'b0;
                extinct_reg   <= (seed == '0);
            end else if (commit) begin
                grid_reg    <= next_grid;
                stable_reg  <= (next_grid == grid_reg);
                extinct_reg <= (next_grid == '0);
                if (gen_count_reg != '1) begin
                    gen_count_reg <= gen_count_reg + GEN_W'(1);
                end
            end
        end
    end

    assign grid      = grid_reg;
    assign gen_count = gen_count_reg;
    assign busy      = (state_reg == RUN) || (state_reg == STEP);
    assign stable    = stable_reg;
    assign extinct   = extinct_reg;
    assign halted    = (state_reg == HALT);

endmodule

// File: tb/tb_life_seq_ctrl.sv
module tb_life_seq_ctrl;
    import life_pkg::*;

    localparam int DIV_W = 8;
    localparam int GEN_W = 4;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic [GRID_W-1:0] seed;
    logic              load, run, step, pause, halt_en;
    logic [DIV_W-1:0]  speed_div;
    logic [GRID_W-1:0] next_grid;
    logic [GRID_W-1:0] grid;
    logic [GEN_W-1:0]  gen_count;
    logic              busy, stable, extinct, halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] grid;
        logic [3:0]  gen;
        logic        busy;
        logic        stable;
        logic        extinct;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    life_seq_ctrl #(.DIV_W(DIV_W), .GEN_W(GEN_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .seed      (seed),
        .load      (load),
        .run       (run),
        .step      (step),
        .pause     (pause),
        .halt_en   (halt_en),
        .speed_div (speed_div),
        .next_grid (next_grid),
        .grid      (grid),
        .gen_count (gen_count),
        .busy      (busy),
        .stable    (stable),
        .extinct   (extinct),
        .halted    (halted)
    );

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < 8) &&
                            (c + dc >= 0) && (c + dc < 8)) begin
                            if (g[(r + dr) * 8 + (c + dc)]) cnt++;
                        end
                    end
                end
                n[r * 8 + c] = g[r * 8 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    always_comb next_grid = life_next(grid);

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (grid !== e.grid || gen_count !== e.gen || busy !== e.busy ||
                stable !== e.stable || extinct !== e.extinct || halted !== e.halted) begin
                errors++;
                $display("FAIL %s: got grid=%h gen=%0d busy=%b stable=%b extinct=%b halted=%b, want grid=%h gen=%0d busy=%b stable=%b extinct=%b halted=%b",
                         e.tag, grid, gen_count, busy, stable, extinct, halted,
                         e.grid, e.gen, e.busy, e.stable, e.extinct, e.halted);
            end else begin
                $display("ok   %s: grid=%h gen=%0d busy=%b stable=%b extinct=%b halted=%b",
                         e.tag, grid, gen_count, busy, stable, extinct, halted);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [63:0] g, input int gen,
                                input logic b, input logic s, input logic x, input logic h);
        exp_t e;
        e.tag = tag; e.grid = g; e.gen = 4'(gen);
        e.busy = b; e.stable = s; e.extinct = x; e.halted = h;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] grid_before;

        reset = 1'b1; seed = '0; load = 0; run = 0; step = 0; pause = 0;
        halt_en = 0; speed_div = '0;
        tick(); tick();
        expect_state("reset", 64'h0, 0, 0, 0, 1, 0);
        reset = 1'b0;

        seed = BLINK_H; load = 1; tick(); load = 0;
        expect_state("t1_load", BLINK_H, 0, 0, 0, 0, 0);
        step = 1; tick(); step = 0;
        expect_state("t1_step_busy", BLINK_H, 0, 1, 0, 0, 0);
        tick();
        expect_state("t1_step_done", BLINK_V, 1, 0, 0, 0, 0);

        speed_div = 3; run = 1; tick();
        expect_state("t2_enter_run", BLINK_V, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 18; i++) begin
            int n;
            tick();
            n = i / 4;
            expect_state($sformatf("t2_run_clk%0d", i), (n % 2 == 1) ? BLINK_H : BLINK_V,
                         1 + n, 1, 0, 0, 0);
        end
        pause = 1; run = 0; tick(); pause = 0;
        expect_state("t2_pause", BLINK_V, 5, 0, 0, 0, 0);
        tick(); tick();
        expect_state("t2_idle_hold", BLINK_V, 5, 0, 0, 0, 0);

        halt_en = 1; seed = BLOCK; load = 1; tick(); load = 0;
        expect_state("t3_load", BLOCK, 0, 0, 0, 0, 0);
        speed_div = 0; run = 1; tick();
        expect_state("t3_enter_run", BLOCK, 0, 1, 0, 0, 0);
        tick();
        expect_state("t3_halt", BLOCK, 1, 0, 1, 0, 1);
        tick(); tick();
        expect_state("t3_frozen", BLOCK, 1, 0, 1, 0, 1);
        run = 0;

        seed = SINGLE; load = 1; tick(); load = 0;
        expect_state("t4_load", SINGLE, 0, 0, 0, 0, 0);
        step = 1; tick(); step = 0;
        expect_state("t4_step_busy", SINGLE, 0, 1, 0, 0, 0);
        tick();
        expect_state("t4_extinct", 64'h0, 1, 0, 0, 1, 1);
        step = 1; tick(); step = 0; tick();
        expect_state("t4_step_in_halt", 64'h0, 1, 0, 0, 1, 1);

        seed = BLINK_H; load = 1; run = 1; speed_div = 1; tick(); load = 0;
        expect_state("t5_load_from_halt", BLINK_H, 0, 0, 0, 0, 0);
        tick();
        expect_state("t5_run_next", BLINK_H, 0, 1, 0, 0, 0);
        tick();
        expect_state("t5_run_no_commit", BLINK_H, 0, 1, 0, 0, 0);
        reset = 1; tick();
        expect_state("t5_reset_mid_run", 64'h0, 0, 0, 0, 1, 0);
        reset = 0; run = 0; tick();
        expect_state("t5_after_reset", 64'h0, 0, 0, 0, 1, 0);

        halt_en = 0; seed = BLINK_H; load = 1; tick(); load = 0;
        expect_state("t6_load", BLINK_H, 0, 0, 0, 0, 0);
        speed_div = 0; run = 1; tick();
        expect_state("t6_enter_run", BLINK_H, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            expect_state($sformatf("t6_commit%0d", k), (k % 2 == 1) ? BLINK_V : BLINK_H,
                         (k > 15) ? 15 : k, 1, 0, 0, 0);
        end

        grid_before = grid;
        tick();
        checks++;
        if (gen_count !== 4'd15 || grid === grid_before) begin
            errors++;
            $display("FAIL t6_saturate_direct: gen=%0d grid=%h prev=%h", gen_count, grid, grid_before);
        end else begin
            $display("ok   t6_saturate_direct: gen=%0d grid=%h prev=%h", gen_count, grid, grid_before);
        end
        run = 0;

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        if (errors == 0 && checks >= 12) begin
            $display("PASS");
        end else begin
            $display("FAIL summary");
        end
        $finish;
    end

endmodule
